decoder_24: RTL and testbench
=============================

DECODER_24 -- requirements
Module: decoder_24

Interface
REQ-001 Parameter IN_W, default 2: select input width; SHALL be legal from 1 to 6.
REQ-002 Parameter OUT_W, default 2**IN_W: decoded output width; SHALL be derived only, never overridden independently.
REQ-003 Parameter ACT_LOW, default 0: when 1, Out SHALL be the bitwise inverse (one-cold).
REQ-004 clk  input  1  sole clock, rising-edge active.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  decode enable, sampled on clk rising edge.
REQ-007 In  input  IN_W  binary select.
REQ-008 Out  output  OUT_W  registered one-hot decode of In.
REQ-009 valid  output  1  high when Out holds a decode produced while en=1.
REQ-010 One clock and asynchronous active-high reset are already decided; all state SHALL be in the clk domain, cleared by rst.

Function
REQ-011 On each rising clk edge with en=1, Out SHALL load a one-hot vector with only bit[In] set, e.g. In=2'b00 -> 4'b0001, 2'b01 -> 4'b0010, 2'b10 -> 4'b0100, 2'b11 -> 4'b1000.
REQ-012 Latency SHALL be exactly one clk cycle from In/en sampling to Out/valid update; no combinational path from In to Out.
REQ-013 On a rising edge with en=0, Out SHALL hold its previous value and valid SHALL go low.
REQ-014 valid SHALL go high on the edge after any cycle sampled with en=1 and stay high only while en remains 1.
REQ-015 With ACT_LOW=0, Out SHALL have exactly one bit set whenever valid=1, and no bit set only after reset before the first enabled decode.
REQ-016 With ACT_LOW=1, every Out value, including the reset value, SHALL be inverted (reset value all ones).
REQ-017 Back-to-back changes of In on consecutive enabled cycles SHALL each be reflected on the following cycle, with no skipped or merged codes.
REQ-018 X/Z on In while en=1 SHALL NOT be decoded silently; simulation SHALL flag it with an assertion, and the synthesised value is don't-care.
REQ-019 All OUT_W codes SHALL be reachable; there is no illegal input code for any legal IN_W.

Reset
REQ-020 Asserting rst SHALL immediately, without a clock edge, force Out to all zeros (all ones if ACT_LOW=1) and valid to 0.
REQ-021 While rst is high, en and In SHALL be ignored.
REQ-022 After rst deasserts, the first decode SHALL appear one cycle after the first rising edge with en=1.
REQ-023 Reset asserted mid-operation SHALL discard the pending decode; no stale code SHALL appear after release.

Structure
REQ-024 Shared package decoder_24_pkg SHALL hold IN_W_DEFAULT=2 and the function computing OUT_W.
REQ-025 One combinational sub-module, dec_core (IN_W -> OUT_W one-hot, no clock), SHALL implement the decode; decoder_24 SHALL add the enable, output register, polarity and valid logic.
REQ-026 The design SHALL include assertions for one-hot Out when valid=1 and ACT_LOW=0, and for X-free In when en=1.

Verification
REQ-027 Reset: assert rst asynchronously between edges -> Out=4'b0000 and valid=0 immediately, before the next edge.
REQ-028 Full sweep: en=1, In = 00, 01, 10, 11 on successive cycles -> Out = 0001, 0010, 0100, 1000 each one cycle later, with valid=1.
REQ-029 Hold: In=2'b10 decoded, then en=0 and In=2'b01 -> Out stays 0100 and valid=0.
REQ-030 Mid-operation reset: en=1, In=2'b11, rst pulsed before the edge -> Out=0000 after release until the next enabled edge.
REQ-031 Polarity: ACT_LOW=1, In=2'b01 -> Out=4'b1101; during reset Out=4'b1111.
REQ-032 Width: IN_W=3, In=3'b101 -> Out=8'b0010_0000 one cycle later.

Source files
------------

// File: rtl/decoder_24_pkg.sv
// Shared parameters and width helpers for the registered binary decoder.
package decoder_24_pkg;

   localparam int IN_W_DEFAULT = 2;
   localparam int IN_W_MIN     = 1;
   localparam int IN_W_MAX     = 6;

   function automatic int out_w(input int in_w);
      return 1 << in_w;
   endfunction

endpackage

// File: rtl/dec_core.sv
// Purely combinational binary-to-one-hot decode; no clock, no state.
module dec_core
   import decoder_24_pkg::*;
#(
   parameter  int IN_W  = IN_W_DEFAULT,
   localparam int OUT_W = out_w(IN_W)
) (
   input  logic [IN_W-1:0]  sel_i,
   output logic [OUT_W-1:0] onehot_o
);

   always_comb begin
      onehot_o        = '0;
      onehot_o[sel_i] = 1'b1;
   end

endmodule

// File: rtl/decoder_24.sv
// Registered one-hot decoder with enable, selectable polarity and valid flag.
module decoder_24
   import decoder_24_pkg::*;
#(
   parameter  int IN_W    = IN_W_DEFAULT,
   parameter  bit ACT_LOW = 1'b0,
   localparam int OUT_W   = out_w(IN_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [IN_W-1:0]  In,
   output logic [OUT_W-1:0] Out,
   output logic             valid
);

   localparam logic [OUT_W-1:0] RST_VAL = {OUT_W{ACT_LOW}};

   logic [OUT_W-1:0] dec;
   logic [OUT_W-1:0] out_d, out_q;
   logic             valid_d, valid_q;

   dec_core #(
      .IN_W (IN_W)
   ) u_core (
      .sel_i    (In),
      .onehot_o (dec)
   );

   // Disabled cycles keep the last code but drop valid.
   always_comb begin
      out_d   = out_q;
      valid_d = en;
      if (en) begin
         out_d = ACT_LOW ? ~dec : dec;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= RST_VAL;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign Out   = out_q;
   assign valid = valid_q;

   a_in_known: assert property (
      @(posedge clk) disable iff (rst)
      en |-> !$isunknown(In)
   );

   a_onehot: assert property (
      @(posedge clk) disable iff (rst)
      (valid && (ACT_LOW == 1'b0)) |-> $onehot(Out)
   );

endmodule

// File: tb/tb_decoder_24.sv
// Table-driven scoreboard bench for decoder_24: default, inverted and 3-bit builds.
module tb_decoder_24;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [1:0] in2 = '0;
   logic [2:0] in3 = '0;
   logic [3:0] out_a, out_l;
   logic [7:0] out_w3;
   logic       v_a, v_l, v_w3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       en;
      logic [1:0] in2;
      logic [2:0] in3;
      logic [3:0] exp2;
      logic [7:0] exp3;
      logic       expv;
   } vec_t;

   vec_t vecs[9];
   vec_t sbq[$];

   always #5 clk = ~clk;

   decoder_24 u_hi (
      .clk(clk), .rst(rst), .en(en), .In(in2),
      .Out(out_a), .valid(v_a)
   );

   decoder_24 #(.ACT_LOW(1'b1)) u_lo (
      .clk(clk), .rst(rst), .en(en), .In(in2),
      .Out(out_l), .valid(v_l)
   );

   decoder_24 #(.IN_W(3)) u_w3 (
      .clk(clk), .rst(rst), .en(en), .In(in3),
      .Out(out_w3), .valid(v_w3)
   );

   task automatic chk(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm,
                          input logic [3:0] e2,
                          input logic [7:0] e3,
                          input logic ev);
      chk({nm, " out"},    {4'h0, out_a}, {4'h0, e2});
      chk({nm, " outlow"}, {4'h0, out_l}, {4'h0, ~e2});
      chk({nm, " out3"},   out_w3, e3);
      chk({nm, " valid"},  {7'd0, v_a}, {7'd0, ev});
      chk({nm, " vlow"},   {7'd0, v_l}, {7'd0, ev});
      chk({nm, " v3"},     {7'd0, v_w3}, {7'd0, ev});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      vecs[0] = '{1'b1, 2'b00, 3'b000, 4'b0001, 8'h01, 1'b1};
      vecs[1] = '{1'b1, 2'b01, 3'b001, 4'b0010, 8'h02, 1'b1};
      vecs[2] = '{1'b1, 2'b10, 3'b010, 4'b0100, 8'h04, 1'b1};
      vecs[3] = '{1'b1, 2'b11, 3'b101, 4'b1000, 8'h20, 1'b1};
      vecs[4] = '{1'b1, 2'b10, 3'b111, 4'b0100, 8'h80, 1'b1};
      vecs[5] = '{1'b0, 2'b01, 3'b011, 4'b0100, 8'h80, 1'b0};
      vecs[6] = '{1'b0, 2'b11, 3'b000, 4'b0100, 8'h80, 1'b0};
      vecs[7] = '{1'b1, 2'b01, 3'b110, 4'b0010, 8'h40, 1'b1};
      vecs[8] = '{1'b1, 2'b01, 3'b011, 4'b0010, 8'h08, 1'b1};

      // async reset between edges
      #1 rst = 1'b1;
      #1 chk_all("reset", 4'b0000, 8'h00, 1'b0);

      // en and In ignored while rst is held across an edge
      en = 1'b1; in2 = 2'b11; in3 = 3'b101;
      @(posedge clk); #1;
      chk_all("rsthold", 4'b0000, 8'h00, 1'b0);
      en = 1'b0;
      #1 rst = 1'b0;

      // no decode until an enabled edge
      @(posedge clk); #1;
      chk_all("idle", 4'b0000, 8'h00, 1'b0);

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         en  = vecs[i].en;
         in2 = vecs[i].in2;
         in3 = vecs[i].in3;
         sbq.push_back(vecs[i]);
         @(posedge clk); #1;
         if (sbq.size() == 0) begin
            chk($sformatf("vec%0d sb", i), 8'd0, 8'd1);
         end else begin
            e = sbq.pop_front();
            chk_all($sformatf("vec%0d", i), e.exp2, e.exp3, e.expv);
         end
      end

      // mid-operation reset drops the pending decode
      @(negedge clk);
      en = 1'b1; in2 = 2'b11; in3 = 3'b101;
      #1 rst = 1'b1;
      #1 chk_all("midrst", 4'b0000, 8'h00, 1'b0);
      #1 rst = 1'b0;
      #1 chk_all("release", 4'b0000, 8'h00, 1'b0);
      @(posedge clk); #1;
      chk_all("afterrel", 4'b1000, 8'h20, 1'b1);

      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      chk_all("final", 4'b1000, 8'h20, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
